mac_operand_feeder: RTL

- Producer side of the 9-element MAC datapath: accepts one image/weight element pair per beat on a valid/ready stream and packs 9 beats into the 72-bit image / 36-bit weight window.
- Issues each window to the MAC with a one-cycle valid and tracks it through the fixed-latency MAC pipeline.
- Captures each 16-bit result into a result FIFO with valid/ready backpressure.
- Credit-based: never issues a window whose result could not be stored.

---
 rtl/mac_feed_pkg.sv | 17 +
 rtl/result_fifo.sv | 53 +++++
 rtl/mac_operand_feeder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mac_feed_pkg.sv
// Shared widths for the 9-element MAC operand feeder.
package mac_feed_pkg;

    localparam int unsigned N_ELEM    = 9;
    localparam int unsigned IMG_W     = 8;
    localparam int unsigned WGT_W     = 4;
    localparam int unsigned BIAS_W    = 5;
    localparam int unsigned OUT_W     = 16;
    localparam int unsigned IMG_VEC_W = N_ELEM * IMG_W;
    localparam int unsigned WGT_VEC_W = N_ELEM * WGT_W;
    localparam int unsigned ELEM_CNT_W = 4;

    function automatic logic is_last_elem(logic [ELEM_CNT_W-1:0] cnt);
        return cnt == ELEM_CNT_W'(N_ELEM - 1);
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous first-word-fall-through FIFO; push and pop may coincide at any occupancy.
module result_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = count == '0;
    assign full    = count == (PTR_W + 1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/mac_operand_feeder.sv
// Packs 9 image/weight beats into a MAC window, issues it, and captures results under credits.
module mac_operand_feeder
    import mac_feed_pkg::*;
#(
    parameter int unsigned MAC_LATENCY = 5,
    parameter int unsigned RES_DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [IMG_W-1:0]     s_image,
    input  logic [WGT_W-1:0]     s_weight,
    input  logic [BIAS_W-1:0]    s_exp_bias,
    output logic                 mac_valid,
    output logic [IMG_VEC_W-1:0] mac_image,
    output logic [WGT_VEC_W-1:0] mac_weight,
    output logic [BIAS_W-1:0]    mac_exp_bias,
    input  logic [OUT_W-1:0]     mac_out,
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic [OUT_W-1:0]     r_data,
    output logic                 busy
);

    localparam int unsigned CRED_W = $clog2(RES_DEPTH) + 1;

    logic [ELEM_CNT_W-1:0]  elem_cnt;
    logic [IMG_VEC_W-1:0]   img_pack;
    logic [WGT_VEC_W-1:0]   wgt_pack;
    logic [BIAS_W-1:0]      bias_pack;
    logic [IMG_VEC_W-1:0]   img_next;
    logic [WGT_VEC_W-1:0]   wgt_next;
    logic [BIAS_W-1:0]      bias_next;
    logic [MAC_LATENCY-1:0] tags;
    logic [CRED_W-1:0]      in_flight;
    logic [CRED_W-1:0]      credits;
    logic [CRED_W-1:0]      fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   last;
    logic                   accept;
    logic                   issue;
    logic                   push;
    logic                   pop;

    assign last    = is_last_elem(elem_cnt);
    assign s_ready = !(last && credits == '0);
    assign accept  = s_valid && s_ready;
    assign issue   = accept && last;
    assign push    = tags[MAC_LATENCY-1];
    assign r_valid = !fifo_empty;
    assign pop     = r_valid && r_ready;
    assign busy    = (elem_cnt != '0) || (|tags) || !fifo_empty;

    // Pack contents with the current beat merged in, so the issue registers see beat 8 directly.
    always_comb begin
        img_next  = img_pack;
        wgt_next  = wgt_pack;
        bias_next = (elem_cnt == '0) ? s_exp_bias : bias_pack;
        img_next[IMG_VEC_W - 1 - IMG_W * int'(elem_cnt) -: IMG_W] = s_image;
        wgt_next[WGT_VEC_W - 1 - WGT_W * int'(elem_cnt) -: WGT_W] = s_weight;
    end

    // Every window from issue until pop holds a credit: pending issue, pipeline tags, FIFO entries.
    always_comb begin
        in_flight = CRED_W'(mac_valid);
        for (int unsigned i = 0; i < MAC_LATENCY; i++) begin
            in_flight = in_flight + CRED_W'(tags[i]);
        end
        credits = CRED_W'(RES_DEPTH) - in_flight - fifo_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            elem_cnt     <= '0;
            img_pack     <= '0;
            wgt_pack     <= '0;
            bias_pack    <= '0;
            mac_valid    <= 1'b0;
            mac_image    <= '0;
            mac_weight   <= '0;
            mac_exp_bias <= '0;
            tags         <= '0;
        end else begin
            if (accept) begin
                img_pack  <= img_next;
                wgt_pack  <= wgt_next;
                bias_pack <= bias_next;
                elem_cnt  <= last ? '0 : elem_cnt + 1'b1;
            end
            mac_valid <= issue;
            if (issue) begin
                mac_image    <= img_next;
                mac_weight   <= wgt_next;
                mac_exp_bias <= bias_next;
            end
            tags <= MAC_LATENCY'({tags, mac_valid});
        end
    end

    result_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (RES_DEPTH)
    ) u_result_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (mac_out),
        .pop   (pop),
        .dout  (r_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    logic unused_full;
    assign unused_full = fifo_full;

endmodule
